// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, cause codes, sequencer states
// and the exception-enable rule used by the register file.
package cp0_pkg;

  localparam int          DATA_W       = 32;
  localparam int          STATUS_SHIFT = 5;
  localparam logic [31:0] EXC_VECTOR   = 32'h0040_0004;
  localparam logic [31:0] STATUS_RST   = 32'h0000_000F;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] CODE_SYSCALL = 5'd8;
  localparam logic [4:0] CODE_BREAK   = 5'd9;
  localparam logic [4:0] CODE_TEQ     = 5'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXC_CAUSE,
    ST_EXC_EPC,
    ST_EXC_STATUS,
    ST_ERET_STATUS,
    ST_DONE
  } cp0_state_e;

  // en[0] is the global enable; en[3:1] mask SYSCALL/BREAK/TEQ individually.
  function automatic logic exc_enabled(input logic [3:0] en, input logic [4:0] code);
    logic ok;
    case (code)
      CODE_SYSCALL: ok = en[1];
      CODE_BREAK:   ok = en[2];
      CODE_TEQ:     ok = en[3];
      default:      ok = 1'b1;
    endcase
    return en[0] & ok;
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 access bus between the control unit (master) and the CP0 register file (slave).
interface cp0_regfile_if;
  import cp0_pkg::*;

  logic              CP0_WE;
  logic [4:0]        CP0_W_ADDR;
  logic [DATA_W-1:0] CP0_W_DATA;
  logic [4:0]        CP0_R_ADDR;
  logic [DATA_W-1:0] CP0_R_DATA;
  logic              EXC_REQ;
  logic [4:0]        EXC_CODE;
  logic [DATA_W-1:0] EXC_PC;
  logic              ERET_REQ;
  logic              BUSY;
  logic              EXC_DONE;
  logic              EXC_TAKEN;
  logic [DATA_W-1:0] PC_REDIRECT;

  modport master (
    output CP0_WE, CP0_W_ADDR, CP0_W_DATA, CP0_R_ADDR, EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ,
    input  CP0_R_DATA, BUSY, EXC_DONE, EXC_TAKEN, PC_REDIRECT
  );

  modport slave (
    input  CP0_WE, CP0_W_ADDR, CP0_W_DATA, CP0_R_ADDR, EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ,
    output CP0_R_DATA, BUSY, EXC_DONE, EXC_TAKEN, PC_REDIRECT
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 STATUS/CAUSE/EPC storage with MTC0/MFC0 access and the multi-cycle
// exception-entry / ERET sequencer.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cp0_regfile_if.slave bus
);

  cp0_state_e        state_q, state_d;
  logic [DATA_W-1:0] status_q, cause_q, epc_q, redirect_q;
  logic              taken_q;
  logic [4:0]        code_q;
  logic [DATA_W-1:0] pc_q;
  logic              exc_en;
  logic              mtc0_ok;

  assign exc_en  = exc_enabled(status_q[3:0], bus.EXC_CODE);
  assign mtc0_ok = (state_q == ST_IDLE) && bus.CP0_WE && !bus.EXC_REQ && !bus.ERET_REQ;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Exception beats ERET when both are raised in the same idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.EXC_REQ)       state_d = exc_en ? ST_EXC_CAUSE : ST_DONE;
        else if (bus.ERET_REQ) state_d = ST_ERET_STATUS;
      end
      ST_EXC_CAUSE:   state_d = ST_EXC_EPC;
      ST_EXC_EPC:     state_d = ST_EXC_STATUS;
      ST_EXC_STATUS:  state_d = ST_DONE;
      ST_ERET_STATUS: state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY     = (state_q != ST_IDLE);
    bus.EXC_DONE = (state_q == ST_DONE);
  end

  // Request operands are frozen at acceptance so the requester may change them.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.EXC_REQ) begin
      code_q <= bus.EXC_CODE;
      pc_q   <= bus.EXC_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      taken_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.EXC_REQ && !exc_en) begin
            taken_q <= 1'b0;
          end else if (mtc0_ok) begin
            case (bus.CP0_W_ADDR)
              ADDR_STATUS: status_q <= bus.CP0_W_DATA;
              ADDR_CAUSE:  cause_q  <= bus.CP0_W_DATA;
              ADDR_EPC:    epc_q    <= bus.CP0_W_DATA;
              default: ;
            endcase
          end
        end
        ST_EXC_CAUSE: cause_q <= {25'b0, code_q, 2'b00};
        ST_EXC_EPC:   epc_q   <= pc_q;
        ST_EXC_STATUS: begin
          status_q   <= status_q << STATUS_SHIFT;
          taken_q    <= 1'b1;
          redirect_q <= EXC_VECTOR;
        end
        ST_ERET_STATUS: begin
          status_q   <= status_q >> STATUS_SHIFT;
          taken_q    <= 1'b1;
          redirect_q <= epc_q;
        end
        default: ;
      endcase
    end
  end

  // MFC0 reads the registered state directly; a same-cycle MTC0 is not bypassed.
  always_comb begin
    bus.CP0_R_DATA = '0;
    case (bus.CP0_R_ADDR)
      ADDR_STATUS: bus.CP0_R_DATA = status_q;
      ADDR_CAUSE:  bus.CP0_R_DATA = cause_q;
      ADDR_EPC:    bus.CP0_R_DATA = epc_q;
      default: ;
    endcase
  end

  assign bus.EXC_TAKEN   = taken_q;
  assign bus.PC_REDIRECT = redirect_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized scoreboard bench for cp0_regfile: a transaction-level CP0 model
// predicts completions and MFC0 values, a monitor compares them as they appear.
module tb_cp0_regfile;

  typedef struct {
    bit          taken;
    bit          chk_pc;
    logic [31:0] redir;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rd_chk = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_status, m_cause, m_epc;

  cp0_regfile_if bus();

  cp0_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares MFC0 samples and every completion against the scoreboard.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) chk("mfc0_no_expect", 32'd1, 32'd0);
      else chk("mfc0_data", bus.CP0_R_DATA, rd_q.pop_front());
    end
    if (!rst && bus.EXC_DONE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_exc_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("exc_taken", {31'b0, bus.EXC_TAKEN}, {31'b0, e.taken});
        if (e.chk_pc) chk("pc_redirect", bus.PC_REDIRECT, e.redir);
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_enabled(input logic [4:0] code);
    if (!m_status[0])  return 1'b0;
    if (code == 5'd8)  return m_status[1];
    if (code == 5'd9)  return m_status[2];
    if (code == 5'd13) return m_status[3];
    return 1'b1;
  endfunction

  function automatic void m_reset();
    m_status = 32'h0000_000F;
    m_cause  = 32'h0;
    m_epc    = 32'h0;
  endfunction

  task automatic rd(input logic [4:0] a);
    logic [31:0] e;
    case (a)
      5'd12:   e = m_status;
      5'd13:   e = m_cause;
      5'd14:   e = m_epc;
      default: e = 32'h0;
    endcase
    bus.CP0_R_ADDR = a;
    rd_q.push_back(e);
    rd_chk = 1'b1;
    step();
    rd_chk = 1'b0;
  endtask

  task automatic rd_all();
    rd(5'd12);
    rd(5'd13);
    rd(5'd14);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.CP0_WE = 1'b1;
    bus.CP0_W_ADDR = a;
    bus.CP0_W_DATA = d;
    if (a == 5'd12) m_status = d;
    if (a == 5'd13) m_cause = d;
    if (a == 5'd14) m_epc = d;
    step();
    bus.CP0_WE = 1'b0;
  endtask

  // One exception and/or ERET request, held until EXC_DONE, with optional
  // colliding MTC0 traffic and operand churn that must all be ignored.
  task automatic do_req(input bit x, input bit e, input logic [4:0] code,
                        input logic [31:0] pc, input bit collide);
    exp_t ex;
    bit   done;
    bus.EXC_REQ    = x;
    bus.ERET_REQ   = e;
    bus.EXC_CODE   = code;
    bus.EXC_PC     = pc;
    bus.CP0_WE     = collide;
    bus.CP0_W_ADDR = 5'd12 + 5'($urandom_range(0, 2));
    bus.CP0_W_DATA = $urandom;
    if (x) begin
      ex.taken  = m_enabled(code);
      ex.chk_pc = ex.taken;
      ex.redir  = 32'h0040_0004;
      if (ex.taken) begin
        m_cause  = 32'(code) * 4;
        m_epc    = pc;
        m_status = m_status << 5;
        ex.done_cyc = cyc + 4;
      end else begin
        ex.done_cyc = cyc + 1;
      end
    end else begin
      ex.taken    = 1'b1;
      ex.chk_pc   = 1'b1;
      ex.redir    = m_epc;
      m_status    = m_status >> 5;
      ex.done_cyc = cyc + 2;
    end
    exp_q.push_back(ex);
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.EXC_DONE) begin
        done = 1'b1;
        break;
      end
      step();
      if (i == 0) chk("busy_active", {31'b0, bus.BUSY}, 32'd1);
      bus.CP0_WE     = 1'($urandom_range(0, 1));
      bus.CP0_W_ADDR = 5'd12 + 5'($urandom_range(0, 2));
      bus.CP0_W_DATA = $urandom;
      bus.EXC_CODE   = 5'($urandom);
      bus.EXC_PC     = $urandom;
    end
    bus.EXC_REQ  = 1'b0;
    bus.ERET_REQ = 1'b0;
    bus.CP0_WE   = 1'b0;
    if (!done) chk("exc_done_timeout", 32'd1, 32'd0);
    step();
    chk("busy_idle", {31'b0, bus.BUSY}, 32'd0);
  endtask

  initial begin
    bus.CP0_WE = 1'b0; bus.CP0_W_ADDR = '0; bus.CP0_W_DATA = '0; bus.CP0_R_ADDR = '0;
    bus.EXC_REQ = 1'b0; bus.EXC_CODE = '0; bus.EXC_PC = '0; bus.ERET_REQ = 1'b0;
    m_reset();
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'b0, bus.EXC_DONE}, 32'd0);
    chk("rst_taken", {31'b0, bus.EXC_TAKEN}, 32'd0);
    chk("rst_redirect", bus.PC_REDIRECT, 32'd0);
    rd_all();
    rd(5'd7);

    wr(5'd14, 32'hDEAD_BEEF);
    rd(5'd14);

    wr(5'd12, 32'h0000_000F);
    do_req(1'b1, 1'b0, 5'd8, 32'h0040_0100, 1'b0);
    rd_all();
    do_req(1'b0, 1'b1, 5'd0, 32'h0, 1'b0);
    rd_all();

    wr(5'd12, 32'h0000_000B);
    do_req(1'b1, 1'b0, 5'd9, 32'h1234_5678, 1'b0);
    rd_all();

    wr(5'd12, 32'h0000_000F);
    do_req(1'b1, 1'b1, 5'd13, 32'h0040_0200, 1'b1);
    rd_all();

    // Reset while the sequencer sits in the EPC step.
    wr(5'd12, 32'h0000_000F);
    bus.EXC_REQ = 1'b1; bus.EXC_CODE = 5'd8; bus.EXC_PC = 32'h0040_0300;
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("midrst_done", {31'b0, bus.EXC_DONE}, 32'd0);
    rst = 1'b0;
    bus.EXC_REQ = 1'b0;
    m_reset();
    chk("midrst_taken", {31'b0, bus.EXC_TAKEN}, 32'd0);
    chk("midrst_redirect", bus.PC_REDIRECT, 32'd0);
    rd_all();

    for (int n = 0; n < 80; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd12 + 5'($urandom_range(0, 2));
        wr(a, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom);
      end else if (op <= 6) begin
        logic [4:0] c;
        case ($urandom_range(0, 3))
          0:       c = 5'd8;
          1:       c = 5'd9;
          2:       c = 5'd13;
          default: c = 5'($urandom);
        endcase
        do_req(1'b1, 1'($urandom_range(0, 1)), c, $urandom, 1'($urandom_range(0, 1)));
        rd_all();
      end else if (op <= 8) begin
        do_req(1'b0, 1'b1, 5'd0, 32'h0, 1'($urandom_range(0, 1)));
        rd_all();
      end else begin
        rd(5'($urandom));
      end
    end

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file and exception sequencer for the multi-cycle MIPS core. It is the storage end of the CP0 write path: it accepts MTC0 writes addressed by the CP0 write-address select logic, serves MFC0 reads, and autonomously sequences the CAUSE → EPC → STATUS updates on exception entry and the STATUS restore on ERET. It sits beside the GPR file and is driven by the control-unit FSM.

## Interface
- EXC_VECTOR, 32'h0040_0004: handler entry address.
- STATUS_RST, 32'h0000_000F: STATUS reset value.
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- CP0_WE  in  1  MTC0 write strobe
- CP0_W_ADDR  in  5  MTC0 destination register number
- CP0_W_DATA  in  32  MTC0 data (rt)
- CP0_R_ADDR  in  5  MFC0 source register number (rd)
- CP0_R_DATA  out  32  MFC0 read data
- EXC_REQ  in  1  exception request, level, held until EXC_DONE
- EXC_CODE  in  5  cause code: 8 SYSCALL, 9 BREAK, 13 TEQ
- EXC_PC  in  32  PC of faulting instruction
- ERET_REQ  in  1  ERET request, level, held until EXC_DONE
- BUSY  out  1  sequencer not idle
- EXC_DONE  out  1  one-cycle completion pulse
- EXC_TAKEN  out  1  valid with EXC_DONE; 1 = exception accepted
- PC_REDIRECT  out  32  EXC_VECTOR after exception, EPC after ERET; valid with EXC_DONE

## Operation
- Implemented registers: STATUS (12), CAUSE (13), EPC (14). All other addresses: reads return 0, writes are discarded.
- MFC0 read: combinational from CP0_R_ADDR; reflects the register state as of the last clock edge (no write-through bypass).
- MTC0 write: accepted only in IDLE with no EXC_REQ/ERET_REQ asserted in the same cycle; otherwise it is dropped.
- Enable check: STATUS[0] is the global enable. STATUS[1], [2], [3] mask SYSCALL, BREAK and TEQ respectively. Any other EXC_CODE is always taken when STATUS[0] = 1.
- FSM states: IDLE, EXC_CAUSE, EXC_EPC, EXC_STATUS, ERET_STATUS, DONE.
  - IDLE + EXC_REQ, enabled → EXC_CAUSE. Disabled → DONE with EXC_TAKEN = 0 and no register changes.
  - EXC_CAUSE: CAUSE ← {25'b0, EXC_CODE, 2'b00}; → EXC_EPC.
  - EXC_EPC: EPC ← EXC_PC; → EXC_STATUS.
  - EXC_STATUS: STATUS ← STATUS << 5; → DONE, with PC_REDIRECT = EXC_VECTOR and EXC_TAKEN = 1.
  - IDLE + ERET_REQ → ERET_STATUS: STATUS ← STATUS >> 5 (logical); → DONE, with PC_REDIRECT = EPC and EXC_TAKEN = 1.
  - DONE: EXC_DONE = 1; → IDLE.
- EXC_CODE and EXC_PC are captured in IDLE on acceptance. Later changes to them have no effect.
- If EXC_REQ and ERET_REQ are both asserted in IDLE, the exception wins and ERET_REQ is ignored.
- Requests still asserted in the cycle after DONE are treated as new requests. The requester must drop them on EXC_DONE.

## Timing
- Reset: STATUS = STATUS_RST, CAUSE = 0, EPC = 0, FSM = IDLE, BUSY = 0, EXC_DONE = 0, EXC_TAKEN = 0, PC_REDIRECT = 0. Reset mid-sequence aborts immediately; partial updates already written are overwritten by the reset values.
- MTC0: register updated at the edge ending the write cycle; visible on CP0_R_DATA the next cycle.
- Taken exception: 5 cycles from the first EXC_REQ cycle to EXC_DONE (IDLE, CAUSE, EPC, STATUS, DONE).
- Masked exception: 2 cycles.
- ERET: 3 cycles.
- BUSY is high in every state except IDLE.
- EXC_TAKEN and PC_REDIRECT are registered and held until the next EXC_DONE.

## Structure
- Shared package cp0_pkg holds:
  - CP0 addresses: 12, 13, 14.
  - Cause codes: 8, 9, 13.
  - FSM state enum.
  - STATUS shift amount: 5.
- No sub-module; a single module of flat registers plus the FSM.

## Test plan
- Reset, then MFC0 on 12/13/14/7 → 0x0000000F / 0 / 0 / 0. MTC0 14 ← 0xDEADBEEF → read back next cycle.
- SYSCALL, EXC_PC = 0x00400100, STATUS = 0xF → EXC_DONE at cycle 5, CAUSE = 0x20, EPC = 0x00400100, STATUS = 0x1E0, PC_REDIRECT = 0x00400004.
- Then ERET → EXC_DONE at cycle 3, STATUS = 0xF, PC_REDIRECT = 0x00400100.
- STATUS = 0xB, BREAK (mask bit 2 clear) → EXC_DONE at cycle 2, EXC_TAKEN = 0, CAUSE/EPC/STATUS unchanged.
- MTC0 write and EXC_REQ in the same IDLE cycle, or MTC0 while BUSY → write dropped, exception completes normally.
- rst asserted in EXC_EPC → next cycle all registers at reset values, BUSY = 0, no EXC_DONE.
